// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for the pipelined adder.
// The slave side is the adder itself; the master side is whoever feeds and drains it.
interface add_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/add_pipe.sv
// Pipelined two's-complement adder/subtractor: one CW-bit chunk per stage, carry registered
// between stages, flags formed in the last stage. One operation per clock, global stall.
module add_pipe #(
  parameter int WIDTH    = 16,
  parameter int SEGMENTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  add_pipe_if.slave   bus
);
  localparam int CW = WIDTH / SEGMENTS;

  if (WIDTH % SEGMENTS != 0) begin : g_bad_width
    $error("add_pipe: WIDTH must be a multiple of SEGMENTS");
  end

  logic stall;
  logic advance;

  // Inputs seen by each stage: stage 0 from the port, stage k from register k-1.
  logic [WIDTH-1:0] st_a  [SEGMENTS];
  logic [WIDTH-1:0] st_bx [SEGMENTS];
  logic [WIDTH-1:0] st_r  [SEGMENTS];
  logic             st_c  [SEGMENTS];
  logic             st_v  [SEGMENTS];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  assign stall   = out_valid_q && !bus.out_ready;
  assign advance = !stall;

  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  // Subtraction is A + ~B + 1, so the carry-in is forced high and cin is ignored.
  assign st_a[0]  = bus.a;
  assign st_bx[0] = bus.sub ? ~bus.b : bus.b;
  assign st_c[0]  = bus.sub | bus.cin;
  assign st_r[0]  = '0;
  assign st_v[0]  = bus.in_valid && !stall;

  for (genvar gi = 0; gi < SEGMENTS; gi++) begin : g_stage
    logic [CW:0]      chunk_sum;
    logic [WIDTH-1:0] r_next;

    always_comb begin
      chunk_sum = {1'b0, st_a[gi][gi*CW +: CW]} + {1'b0, st_bx[gi][gi*CW +: CW]}
                + {{CW{1'b0}}, st_c[gi]};
      r_next = st_r[gi];
      r_next[gi*CW +: CW] = chunk_sum[CW-1:0];
    end

    if (gi < SEGMENTS - 1) begin : g_mid
      logic             v_q, v_d;
      logic             c_q, c_d;
      logic [WIDTH-1:0] a_q, a_d;
      logic [WIDTH-1:0] bx_q, bx_d;
      logic [WIDTH-1:0] r_q, r_d;

      // Bubbles advance exactly like real operations; nothing collapses.
      always_comb begin
        v_d  = v_q;
        c_d  = c_q;
        a_d  = a_q;
        bx_d = bx_q;
        r_d  = r_q;
        if (advance) begin
          v_d  = st_v[gi];
          c_d  = chunk_sum[CW];
          a_d  = st_a[gi];
          bx_d = st_bx[gi];
          r_d  = r_next;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q  <= 1'b0;
          c_q  <= 1'b0;
          a_q  <= '0;
          bx_q <= '0;
          r_q  <= '0;
        end else begin
          v_q  <= v_d;
          c_q  <= c_d;
          a_q  <= a_d;
          bx_q <= bx_d;
          r_q  <= r_d;
        end
      end

      assign st_v[gi+1]  = v_q;
      assign st_c[gi+1]  = c_q;
      assign st_a[gi+1]  = a_q;
      assign st_bx[gi+1] = bx_q;
      assign st_r[gi+1]  = r_q;
    end else begin : g_last
      // Result/flags only change when a valid operation lands, so they keep the last result.
      always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (advance) begin
          out_valid_d = st_v[gi];
          if (st_v[gi]) begin
            sum_d  = r_next;
            cout_d = chunk_sum[CW];
            ovf_d  = (st_a[gi][WIDTH-1] == st_bx[gi][WIDTH-1]) &&
                     (r_next[WIDTH-1] != st_a[gi][WIDTH-1]);
            zero_d = ~|r_next;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
          zero_q      <= 1'b0;
        end else begin
          out_valid_q <= out_valid_d;
          sum_q       <= sum_d;
          cout_q      <= cout_d;
          ovf_q       <= ovf_d;
          zero_q      <= zero_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: directed latency/flag/stall/reset cases plus random
// traffic scored against a queue-based reference model; a second instance covers SEGMENTS=1.
module tb_add_pipe;
  localparam int W   = 16;
  localparam int SEG = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           adv;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exp_t q[$];
  exp_t last;

  add_pipe_if #(.WIDTH(W)) bus0 ();
  add_pipe_if #(.WIDTH(W)) bus1 ();

  add_pipe #(.WIDTH(W), .SEGMENTS(SEG)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  add_pipe #(.WIDTH(W), .SEGMENTS(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bx} + ((sub || cin) ? 17'd1 : 17'd0);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bx[W-1]) && (e.sum[W-1] != a[W-1]);
    e.zero = (e.sum == 0);
    e.adv  = 1;
    return e;
  endfunction

  // Reference model: ops in flight in order; each unstalled edge ages them by one stage.
  always @(negedge clk) begin : monitor
    exp_t cur;
    logic exp_ov;
    logic stall;
    if (rst) begin
      q.delete();
      last = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, adv: 0};
    end else begin
      exp_ov = (q.size() > 0) && (q[0].adv >= SEG);
      cur    = exp_ov ? q[0] : last;
      chk("m_out_valid", bus0.out_valid, exp_ov);
      chk("m_sum", bus0.sum, cur.sum);
      chk("m_cout", bus0.cout, cur.cout);
      chk("m_ovf", bus0.ovf, cur.ovf);
      chk("m_zero", bus0.zero, cur.zero);
      stall = exp_ov && !bus0.out_ready;
      chk("m_in_ready", bus0.in_ready, !stall);
      if (!stall) begin
        if (exp_ov) last = q.pop_front();
        foreach (q[i]) q[i].adv++;
        if (bus0.in_valid) q.push_back(ref_op(bus0.a, bus0.b, bus0.sub, bus0.cin));
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    bus0.a        = a;
    bus0.b        = b;
    bus0.sub      = sub;
    bus0.cin      = cin;
    bus0.in_valid = 1'b1;
  endtask

  task automatic op_lat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin, input logic [W-1:0] e_sum,
                        input logic e_cout, input logic e_ovf, input logic e_zero);
    bus0.out_ready = 1'b1;
    drive(a, b, sub, cin);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    for (int e = 0; e < SEG - 1; e++) begin
      @(negedge clk);
      chk({tag, "_early"}, bus0.out_valid, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_valid"}, bus0.out_valid, 1'b1);
    chk({tag, "_sum"}, bus0.sum, e_sum);
    chk({tag, "_cout"}, bus0.cout, e_cout);
    chk({tag, "_ovf"}, bus0.ovf, e_ovf);
    chk({tag, "_zero"}, bus0.zero, e_zero);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return W'($urandom());
    endcase
  endfunction

  task automatic stream3();
    drive(16'h0000, 16'h0010, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h0010, 16'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h0010, 16'h0010, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(16'h1234, 16'h4321, 1'b0, 1'b0);
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.sub       = 1'b0;
    bus1.cin       = 1'b0;
    bus1.out_ready = 1'b1;

    // Reset held two cycles with in_valid high
    repeat (2) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus0.out_valid, 1'b0);
    chk("rst_sum", bus0.sum, 16'h0000);
    chk("rst_cout", bus0.cout, 1'b0);
    chk("rst_ovf", bus0.ovf, 1'b0);
    chk("rst_zero", bus0.zero, 1'b0);
    chk("rst_in_ready", bus0.in_ready, 1'b1);
    @(posedge clk); #1;

    op_lat("add_basic", 16'h0100, 16'h0010, 1'b0, 1'b0, 16'h0110, 1'b0, 1'b0, 1'b0);
    op_lat("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op_lat("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    op_lat("sub_eq",    16'h0010, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    op_lat("sub_neg",   16'h0000, 16'h0010, 1'b1, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0);
    op_lat("add_cin",   16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream at full rate
    bus0.out_ready = 1'b1;
    stream3();
    @(negedge clk);
    chk("stream_pre", bus0.out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_v0", bus0.out_valid, 1'b1);
    chk("stream_s0", bus0.sum, 16'h0010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_v1", bus0.out_valid, 1'b1);
    chk("stream_s1", bus0.sum, 16'h0010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_v2", bus0.out_valid, 1'b1);
    chk("stream_s2", bus0.sum, 16'h0020);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_end", bus0.out_valid, 1'b0);
    @(posedge clk); #1;

    // Same stream with a three-cycle output stall
    bus0.out_ready = 1'b0;
    stream3();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", bus0.out_valid, 1'b1);
      chk("stall_sum", bus0.sum, 16'h0010);
      chk("stall_in_ready", bus0.in_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("drain_s0", bus0.sum, 16'h0010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_s1", bus0.sum, 16'h0010);
    chk("drain_v1", bus0.out_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_s2", bus0.sum, 16'h0020);
    chk("drain_v2", bus0.out_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_end", bus0.out_valid, 1'b0);
    @(posedge clk); #1;

    // Reset while two operations are in flight
    drive(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(16'h0003, 16'h0004, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    rst           = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_valid", bus0.out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Single-stage instance
    @(negedge clk);
    chk("s1_idle", bus1.out_valid, 1'b0);
    @(posedge clk); #1;
    bus1.a        = 16'h0000;
    bus1.b        = 16'h0010;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("s1_valid", bus1.out_valid, 1'b1);
    chk("s1_sum", bus1.sum, 16'h0010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s1_end", bus1.out_valid, 1'b0);
    @(posedge clk); #1;

    // Random traffic with random backpressure
    for (int i = 0; i < 500; i++) begin
      bus0.in_valid  = 1'($urandom_range(0, 1));
      bus0.a         = pick();
      bus0.b         = pick();
      bus0.sub       = 1'($urandom_range(0, 1));
      bus0.cin       = 1'($urandom_range(0, 1));
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    repeat (2 * SEG + 2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("final_empty", q.size(), 0);
    chk("final_valid", bus0.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
